// File: rtl/uart_tx_scheduler_pkg.sv
// Shared constants for the UART transmit scheduler: FSM encodings, status word
// layout and default bus addresses.
package uart_sched_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle     = 2'd0;
    localparam state_t StLoad     = 2'd1;
    localparam state_t StWaitBusy = 2'd2;
    localparam state_t StWaitDone = 2'd3;

    localparam int unsigned StatBusy   = 0;
    localparam int unsigned StatEmpty  = 1;
    localparam int unsigned StatFull   = 2;
    localparam int unsigned StatCntLsb = 3;
    localparam int unsigned StatCntW   = 7;
    localparam int unsigned StatTmo    = 10;
    localparam int unsigned StatOvf    = 11;

    localparam logic [31:0] AddrTxdDefault  = 32'h4000_0018;
    localparam logic [31:0] AddrStatDefault = 32'h4000_0024;

    function automatic logic [31:0] pack_status(input logic                busy,
                                                input logic                empty,
                                                input logic                full,
                                                input logic [StatCntW-1:0] cnt,
                                                input logic                tmo,
                                                input logic                ovf);
        logic [31:0] s;
        s                           = '0;
        s[StatBusy]                 = busy;
        s[StatEmpty]                = empty;
        s[StatFull]                 = full;
        s[StatCntLsb +: StatCntW]   = cnt;
        s[StatTmo]                  = tmo;
        s[StatOvf]                  = ovf;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Peripheral-bus and sender-side signals of the UART transmit scheduler.
interface uart_tx_scheduler_if;

    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx_status;
    logic        txstop;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        irq_empty;

    modport master (
        output wr, rd, addr, wdata, tx_status, txstop,
        input  rdata, tx_en, tx_data, irq_empty
    );

    modport slave (
        input  wr, rd, addr, wdata, tx_status, txstop,
        output rdata, tx_en, tx_data, irq_empty
    );

endinterface

// File: rtl/uart_tx_scheduler_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Depth is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Buffers bytes written to the transmit address and launches them one at a time
// into the UART sender, waiting out each frame before the next launch.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int unsigned Depth    = 8,
    parameter logic [31:0] AddrTxd  = AddrTxdDefault,
    parameter logic [31:0] AddrStat = AddrStatDefault,
    parameter int unsigned Tmo      = 255
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    uart_tx_scheduler_if.slave  bus
);

    localparam int unsigned CntW = $clog2(Depth) + 1;
    localparam int unsigned TmoW = $clog2(Tmo + 1);

    state_t          state_q, state_d;
    logic [TmoW-1:0] wait_cnt_q, wait_cnt_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tmo_q, tmo_d;
    logic            ovf_q, ovf_d;

    logic            push_req, stat_wr, pop, tmo_set, ovf_set;
    logic            fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic [7:0]      fifo_head;

    assign push_req = bus.wr && (bus.addr == AddrTxd);
    assign stat_wr  = bus.wr && (bus.addr == AddrStat);
    assign pop      = (state_q == StLoad);
    assign ovf_set  = push_req && fifo_full && !pop;

    sync_fifo #(
        .Width (8),
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_req),
        .pop_i   (pop),
        .wdata_i (bus.wdata[7:0]),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        tmo_set    = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty && !bus.txstop && !bus.tx_status) state_d = StLoad;
            end
            StLoad: begin
                state_d    = StWaitBusy;
                wait_cnt_d = '0;
            end
            StWaitBusy: begin
                if (bus.tx_status) begin
                    state_d = StWaitDone;
                end else if (wait_cnt_q == TmoW'(Tmo - 1)) begin
                    // Sender never acknowledged; the byte is abandoned.
                    tmo_set = 1'b1;
                    state_d = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!bus.tx_status) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // A set event in the same cycle as a software clear wins.
    assign tmo_d     = tmo_set | (tmo_q & ~(stat_wr & bus.wdata[StatTmo]));
    assign ovf_d     = ovf_set | (ovf_q & ~(stat_wr & bus.wdata[StatOvf]));
    assign tx_data_d = pop ? fifo_head : tx_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            tx_data_q  <= '0;
            tmo_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            tx_data_q  <= tx_data_d;
            tmo_q      <= tmo_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.rd && (bus.addr == AddrStat)) begin
            bus.rdata = pack_status(state_q != StIdle, fifo_empty, fifo_full,
                                    StatCntW'(fifo_count), tmo_q, ovf_q);
        end
    end

    assign bus.tx_en     = (state_q == StLoad);
    assign bus.tx_data   = tx_data_q;
    assign bus.irq_empty = fifo_empty && (state_q == StIdle);

    logic unused_wdata;
    assign unused_wdata = ^{bus.wdata[31:12], bus.wdata[9:8]};

endmodule
